// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the async_sdram_ctrl command and read FIFOs between NUM_PORTS clients.
// Read responses are returned in issue order and steered back to their port through a tag FIFO.
module sdram_port_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int TAG_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset_n_i,
   input  logic [NUM_PORTS-1:0]    req_valid_i,
   input  logic [NUM_PORTS-1:0]    req_we_i,
   input  logic [NUM_PORTS*24-1:0] req_addr_i,
   input  logic [NUM_PORTS*16-1:0] req_data_i,
   output logic [NUM_PORTS-1:0]    req_ready_o,
   output logic [NUM_PORTS-1:0]    rsp_valid_o,
   output logic [15:0]             rsp_data_o,
   output logic [40:0]             writer_d_o,
   output logic                    writer_enq_o,
   input  logic                    writer_full_i,
   input  logic [15:0]             reader_q_i,
   output logic                    reader_deq_o,
   input  logic                    reader_empty_i,
   output logic                    orphan_o,
   output logic [1:0]              cmd_state_o,
   output logic [1:0]              rsp_state_o
);

   localparam int TW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

   // Handshake: a client holds req_valid_i[i] and its command stable until it sees req_ready_o[i]
   // high for one cycle; that cycle completes the transfer and the client may then drop or change it.
   typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_GAP} cmd_state_t;
   typedef enum logic [1:0] {R_IDLE, R_POP, R_CAP} rsp_state_t;

   cmd_state_t c_state, c_next;
   rsp_state_t r_state, r_next;

   logic [TW-1:0]        rr_q;
   logic [TW-1:0]        grant_idx;
   logic                 grant_found;
   logic [NUM_PORTS-1:0] eligible;
   logic                 issue;
   logic                 grant_we;

   logic [TW-1:0] tag_mem [TAG_DEPTH];
   logic [PW-1:0] tag_wr_ptr, tag_rd_ptr;
   logic [PW:0]   tag_cnt;
   logic          tag_full, tag_empty, tag_push, tag_pop;
   logic          deq_start, cap_hit, cap_orphan;

   function automatic logic [TW-1:0] wrap_add(input logic [TW-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      return TW'(s);
   endfunction

   assign tag_full    = (tag_cnt == (PW+1)'(TAG_DEPTH));
   assign tag_empty   = (tag_cnt == '0);
   assign cmd_state_o = c_state;
   assign rsp_state_o = r_state;

   // Reads need a free tag slot; writes never do, so a full tag FIFO only blocks reads.
   always_comb begin
      eligible    = req_valid_i & (req_we_i | {NUM_PORTS{!tag_full}});
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!grant_found && eligible[wrap_add(rr_q, k)]) begin
            grant_found = 1'b1;
            grant_idx   = wrap_add(rr_q, k);
         end
      end
   end

   always_comb begin
      c_next = c_state;
      issue  = 1'b0;
      case (c_state)
         C_IDLE: begin
            if (!writer_full_i && grant_found) begin
               issue  = 1'b1;
               c_next = C_ISSUE;
            end
         end
         C_ISSUE: c_next = C_GAP;
         C_GAP:   c_next = C_IDLE;
         default: c_next = C_IDLE;
      endcase
   end

   assign grant_we = req_we_i[grant_idx];
   assign tag_push = issue && !grant_we;

   always_comb begin
      r_next     = r_state;
      deq_start  = 1'b0;
      cap_hit    = 1'b0;
      cap_orphan = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (!reader_empty_i) begin
               deq_start = 1'b1;
               r_next    = R_POP;
            end
         end
         R_POP: r_next = R_CAP;
         R_CAP: begin
            cap_hit    = !tag_empty;
            cap_orphan = tag_empty;
            r_next     = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign tag_pop = cap_hit;

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         c_state      <= C_IDLE;
         rr_q         <= '0;
         writer_d_o   <= '0;
         writer_enq_o <= 1'b0;
         req_ready_o  <= '0;
      end else begin
         c_state      <= c_next;
         writer_enq_o <= issue;
         req_ready_o  <= issue ? (NUM_PORTS'(1) << grant_idx) : '0;
         if (issue) begin
            writer_d_o <= {grant_we, req_addr_i[grant_idx*24 +: 24], req_data_i[grant_idx*16 +: 16]};
            rr_q       <= wrap_add(grant_idx, 1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state      <= R_IDLE;
         reader_deq_o <= 1'b0;
         rsp_valid_o  <= '0;
         rsp_data_o   <= '0;
         orphan_o     <= 1'b0;
      end else begin
         r_state      <= r_next;
         reader_deq_o <= deq_start;
         rsp_valid_o  <= '0;
         if (cap_hit) begin
            rsp_data_o  <= reader_q_i;
            rsp_valid_o <= NUM_PORTS'(1) << tag_mem[tag_rd_ptr];
         end
         if (cap_orphan) orphan_o <= 1'b1;
      end
   end

   // Tag FIFO: push on a read grant, pop when its data word is captured; both may happen together.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tag_wr_ptr <= '0;
         tag_rd_ptr <= '0;
         tag_cnt    <= '0;
         for (int i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= '0;
      end else begin
         if (tag_push) begin
            tag_mem[tag_wr_ptr] <= grant_idx;
            tag_wr_ptr          <= tag_wr_ptr + 1'b1;
         end
         if (tag_pop) tag_rd_ptr <= tag_rd_ptr + 1'b1;
         case ({tag_push, tag_pop})
            2'b10:   tag_cnt <= tag_cnt + 1'b1;
            2'b01:   tag_cnt <= tag_cnt - 1'b1;
            default: tag_cnt <= tag_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration rules and of the SDRAM controller FIFOs.
module tb_sdram_port_arbiter;

   localparam int NP = 4;
   localparam int TD = 8;

   logic            clk = 1'b0;
   logic            reset_n_i;
   logic [NP-1:0]   req_valid_i, req_we_i, req_ready_o, rsp_valid_o;
   logic [NP*24-1:0] req_addr_i;
   logic [NP*16-1:0] req_data_i;
   logic [15:0]     rsp_data_o, reader_q_i;
   logic [40:0]     writer_d_o;
   logic            writer_enq_o, writer_full_i, reader_deq_o, reader_empty_i, orphan_o;
   logic [1:0]      cmd_state_o, rsp_state_o;

   always #5 clk = ~clk;

   sdram_port_arbiter #(.NUM_PORTS(NP), .TAG_DEPTH(TD)) dut (
      .clk(clk), .reset_n_i(reset_n_i),
      .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .writer_d_o(writer_d_o), .writer_enq_o(writer_enq_o), .writer_full_i(writer_full_i),
      .reader_q_i(reader_q_i), .reader_deq_o(reader_deq_o), .reader_empty_i(reader_empty_i),
      .orphan_o(orphan_o), .cmd_state_o(cmd_state_o), .rsp_state_o(rsp_state_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (negedge) ----------------
   logic [40:0] port_q [NP][$];
   logic [18:0] exp_q [$];               // {port, data} of outstanding reads, in issue order
   logic [16:0] ret_q [$];               // {real, data} words sitting in the ctrl read FIFO
   logic [15:0] mem [logic [23:0]];
   logic [19:0] r_log [$];
   int          g_log [$];
   int          gc_log [$];
   int          cyc, last_rdy, rr_m, outstanding;
   int          n_enq = 0, n_rd_grant = 0, n_wr_grant = 0;
   int          inj_req = 0, inj_done = 0;
   logic        stall_ret = 1'b0;
   logic [40:0] last_cmd;
   logic [NP-1:0] s_valid, s_we, m_exp_rdy, m_onehot;
   logic [23:0] s_addr [NP];
   logic [15:0] s_data [NP];
   logic        s_full, s_idle, m_found;
   int          s_cnt, m_g, m_p;
   logic [18:0] m_e;
   logic [16:0] m_w;
   logic [15:0] m_v;

   always @(negedge clk) begin
      if (!reset_n_i) begin
         cyc = 0; last_rdy = -10; rr_m = 0; outstanding = 0;
         exp_q.delete(); ret_q.delete();
         reader_empty_i = 1'b1; reader_q_i = '0;
         s_valid = '0; s_idle = 1'b0; s_full = 1'b1;
      end else begin
         cyc++;
         if (rsp_valid_o != '0) begin
            if (exp_q.size() == 0) check_eq("rsp_unexpected", rsp_valid_o, '0);
            else begin
               m_e = exp_q.pop_front();
               m_onehot = NP'(1) << m_e[18:16];
               check_eq("rsp_port", rsp_valid_o, m_onehot);
               check_eq("rsp_data", rsp_data_o, m_e[15:0]);
               outstanding--;
            end
            r_log.push_back({rsp_valid_o, rsp_data_o});
         end
         // grant decided last cycle from the snapshot taken then
         m_exp_rdy = '0; m_found = 1'b0; m_g = 0;
         if (s_idle && !s_full) begin
            for (int k = 0; k < NP; k++) begin
               m_p = (rr_m + k) % NP;
               if (!m_found && s_valid[m_p] && (s_we[m_p] || s_cnt < TD)) begin
                  m_found = 1'b1; m_g = m_p;
               end
            end
            if (m_found) m_exp_rdy = NP'(1) << m_g;
         end
         check_eq("grant", req_ready_o, m_exp_rdy);
         check_eq("enq", writer_enq_o, m_found);
         if (writer_enq_o) n_enq++;
         if (m_found) begin
            check_eq("cmd", writer_d_o, {s_we[m_g], s_addr[m_g], s_data[m_g]});
            last_cmd = {s_we[m_g], s_addr[m_g], s_data[m_g]};
            g_log.push_back(m_g); gc_log.push_back(cyc);
            rr_m = (m_g + 1) % NP; last_rdy = cyc;
            if (s_we[m_g]) begin
               mem[s_addr[m_g]] = s_data[m_g];
               n_wr_grant++;
            end else begin
               m_v = mem.exists(s_addr[m_g]) ? mem[s_addr[m_g]] : {s_addr[m_g][7:0], ~s_addr[m_g][7:0]};
               exp_q.push_back({3'(m_g), m_v});
               ret_q.push_back({1'b1, m_v});
               outstanding++; n_rd_grant++;
            end
         end
         if (reader_deq_o) begin
            check_eq("deq_nonempty", reader_empty_i, 1'b0);
            if (ret_q.size() != 0) begin
               m_w = ret_q.pop_front();
               reader_q_i = m_w[15:0];
            end
         end
         if (inj_req > inj_done) begin
            ret_q.push_back({1'b0, 16'hDEAD});
            inj_done++;
         end
         reader_empty_i = stall_ret || (ret_q.size() == 0);
         s_valid = req_valid_i; s_we = req_we_i; s_full = writer_full_i; s_cnt = outstanding;
         for (int i = 0; i < NP; i++) begin
            s_addr[i] = req_addr_i[i*24 +: 24];
            s_data[i] = req_data_i[i*16 +: 16];
         end
         s_idle = (cyc - last_rdy) >= 2;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int p, input logic we, input logic [23:0] a, input logic [15:0] d);
      port_q[p].push_back({we, a, d});
   endtask

   task automatic step();
      logic [40:0] c;
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) begin
         if (req_valid_i[i] && req_ready_o[i]) req_valid_i[i] = 1'b0;
         if (!req_valid_i[i] && port_q[i].size() > 0) begin
            c = port_q[i].pop_front();
            req_valid_i[i] = 1'b1;
            req_we_i[i] = c[40];
            req_addr_i[i*24 +: 24] = c[39:16];
            req_data_i[i*16 +: 16] = c[15:0];
         end
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_idle(input int budget);
      logic busy;
      busy = 1'b1;
      while (busy && budget > 0) begin
         step();
         budget--;
         busy = (req_valid_i != '0) || (exp_q.size() != 0);
         for (int i = 0; i < NP; i++) if (port_q[i].size() != 0) busy = 1'b1;
      end
      check_eq("run_idle_timeout", busy, 1'b0);
      steps(4);
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_data_i = '0;
      writer_full_i = 1'b0; stall_ret = 1'b0;
      for (int i = 0; i < NP; i++) port_q[i].delete();
      repeat (3) @(posedge clk);
      #1 reset_n_i = 1'b1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1);
   end

   initial begin
      int b, w, rb;
      do_reset();
      check_eq("rst_ready", req_ready_o, '0);
      check_eq("rst_rsp_valid", rsp_valid_o, '0);
      check_eq("rst_rsp_data", rsp_data_o, '0);
      check_eq("rst_writer_d", writer_d_o, '0);
      check_eq("rst_enq", writer_enq_o, 1'b0);
      check_eq("rst_deq", reader_deq_o, 1'b0);
      check_eq("rst_orphan", orphan_o, 1'b0);

      // stray read word with no tag; command FIFO reported full
      writer_full_i = 1'b1;
      b = n_enq;
      send(0, 1'b1, 24'h000700, 16'h0007);
      inj_req++;
      steps(12);
      check_eq("t6_orphan", orphan_o, 1'b1);
      check_eq("t6_no_enq", n_enq - b, 0);
      check_eq("t6_no_rsp", r_log.size(), 0);
      writer_full_i = 1'b0;
      steps(6);
      check_eq("t6_enq_after_full", n_enq - b, 1);
      do_reset();
      check_eq("t6_orphan_cleared", orphan_o, 1'b0);

      // single write
      send(0, 1'b1, 24'h001000, 16'h1000);
      run_idle(50);
      check_eq("t1_cmd", last_cmd, 41'h1_001000_1000);
      check_eq("t1_port", g_log[g_log.size()-1], 0);

      // all ports requesting: round-robin, 3 cycles apart
      do_reset();
      b = g_log.size();
      for (int i = 0; i < NP; i++) begin
         send(i, 1'b1, 24'h002000 + 24'(i), 16'hB000 + 16'(i));
         send(i, 1'b1, 24'h002010 + 24'(i), 16'hC000 + 16'(i));
      end
      run_idle(200);
      for (int k = 0; k < 5; k++) check_eq("t2_order", g_log[b+k], k % NP);
      for (int k = 1; k < 5; k++) check_eq("t2_spacing", gc_log[b+k] - gc_log[b+k-1], 3);

      // read back the T1 location on port 2
      rb = r_log.size();
      send(2, 1'b0, 24'h001000, 16'h0000);
      run_idle(100);
      check_eq("t3_rsp", r_log[rb], {4'b0100, 16'h1000});

      // two reads back to back, responses in order
      send(0, 1'b1, 24'h003000, 16'hAAAA);
      send(0, 1'b1, 24'h003001, 16'h5555);
      run_idle(100);
      rb = r_log.size();
      send(1, 1'b0, 24'h003000, 16'h0);
      step();
      send(3, 1'b0, 24'h003001, 16'h0);
      run_idle(100);
      check_eq("t4_first", r_log[rb], {4'b0010, 16'hAAAA});
      check_eq("t4_second", r_log[rb+1], {4'b1000, 16'h5555});

      // tag FIFO full: reads stall, writes still go
      stall_ret = 1'b1;
      b = n_rd_grant;
      for (int i = 0; i <= TD; i++) send(0, 1'b0, 24'h003000 + 24'(i & 1), 16'h0);
      steps(3 * TD + 20);
      w = n_wr_grant;
      send(1, 1'b1, 24'h004000, 16'h1234);
      steps(10);
      check_eq("t5_reads_capped", n_rd_grant - b, TD);
      check_eq("t5_write_granted", n_wr_grant - w, 1);
      stall_ret = 1'b0;
      run_idle(500);
      check_eq("t5_all_reads", n_rd_grant - b, TD + 1);

      // randomized traffic with random back-pressure
      for (int n = 0; n < 60; n++) begin
         for (int j = 0; j < 5; j++)
            send($urandom_range(0, NP-1), 1'($urandom_range(0, 1)),
                 24'h005000 + 24'($urandom_range(0, 7)), 16'($urandom));
         for (int j = 0; j < 10; j++) begin
            writer_full_i = ($urandom_range(0, 3) == 0);
            stall_ret = ($urandom_range(0, 7) == 0);
            step();
         end
      end
      writer_full_i = 1'b0;
      stall_ret = 1'b0;
      run_idle(20000);
      check_eq("final_exp_empty", exp_q.size(), 0);
      check_eq("final_orphan", orphan_o, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
